// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect Four match sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package connect4_pkg;

    // Round / turn scheduler states.
    typedef enum logic [2:0] {
        WAIT_MOVE  = 3'd0,
        DROPPING   = 3'd1,
        CHECK      = 3'd2,
        WIN_HOLD   = 3'd3,
        CLEAR      = 3'd4,
        MATCH_OVER = 3'd5
    } state_t;

    // Player encoding used on the player/winner outputs.
    localparam logic PLR_RED = 1'b0;
    localparam logic PLR_GRN = 1'b1;

    // Width of each round-win score.
    localparam int SCORE_W = 3;

    // A win only counts when it is in the colour of the player who just moved.
    function automatic logic credited_win(input logic plr, input logic win_r, input logic win_g);
        return (plr == PLR_GRN) ? win_g : win_r;
    endfunction

endpackage

// File: rtl/match_sequencer_score_keeper.sv
// Two saturating round-win counters plus match-point compare.
// Latency: score updates one cycle after an increment enable; compare is combinational.
// Backpressure: none; increments at the ceiling are dropped (saturate at max).
module score_keeper
    import connect4_pkg::*;
#(
    parameter int WIN_SCORE = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_inc_red,
    input  logic               i_inc_grn,
    output logic [SCORE_W-1:0] o_score_red,
    output logic [SCORE_W-1:0] o_score_grn,
    output logic               o_red_match,
    output logic               o_grn_match
);

    localparam logic [SCORE_W-1:0] LP_MAX = '1;
    localparam logic [SCORE_W-1:0] LP_WIN = SCORE_W'(WIN_SCORE);

    logic [SCORE_W-1:0] r_score_red;
    logic [SCORE_W-1:0] r_score_grn;

    // Saturating per-player round-win counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_score_red <= '0;
            r_score_grn <= '0;
        end else begin
            if (i_inc_red && (r_score_red != LP_MAX)) begin
                r_score_red <= r_score_red + 1'b1;
            end
            if (i_inc_grn && (r_score_grn != LP_MAX)) begin
                r_score_grn <= r_score_grn + 1'b1;
            end
        end
    end

    assign o_score_red = r_score_red;
    assign o_score_grn = r_score_grn;
    assign o_red_match = (r_score_red == LP_WIN);
    assign o_grn_match = (r_score_grn == LP_WIN);

endmodule

// File: rtl/match_sequencer.sv
// Turn/round scheduler: gates moves to the board, scores rounds, holds win display, clears board.
// Latency: drop_en one cycle after move_req; results sampled in the single CHECK cycle after drop_done.
// Backpressure: move_req is dropped (not queued) outside WAIT_MOVE; stalled drops abort after DROP_TIMEOUT.
module match_sequencer
    import connect4_pkg::*;
#(
    parameter int HOLD_CYCLES  = 48,
    parameter int WIN_SCORE    = 3,
    parameter int DROP_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               move_req,
    input  logic               drop_done,
    input  logic               drop_ok,
    input  logic               win_red,
    input  logic               win_grn,
    input  logic               board_full,
    output logic               player,
    output logic               drop_en,
    output logic               next_round,
    output logic [SCORE_W-1:0] scoreR,
    output logic [SCORE_W-1:0] scoreG,
    output logic               flash,
    output logic               drop_err,
    output logic               match_over,
    output logic               winner
);

    // Hold counter needs at least 3 bits so bit 2 exists as the blink source.
    localparam int HOLD_W = ($clog2(HOLD_CYCLES) < 3) ? 3 : $clog2(HOLD_CYCLES);
    localparam int DROP_W = ($clog2(DROP_TIMEOUT + 1) < 1) ? 1 : $clog2(DROP_TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] LP_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DROP_W-1:0] LP_DROP_LAST = DROP_W'(DROP_TIMEOUT - 1);

    state_t              r_state;
    logic                r_player;
    logic                r_start_player;
    logic [DROP_W-1:0]   r_drop_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_round_won;
    logic                r_drop_en;
    logic                r_next_round;
    logic                r_drop_err;
    logic                r_flash;
    logic                r_match_over;
    logic                r_winner;

    logic                w_credit;
    logic                w_inc_red;
    logic                w_inc_grn;
    logic                w_red_match;
    logic                w_grn_match;
    logic                w_match_point;
    logic [HOLD_W-1:0]   w_hold_nxt;

    // Only the mover's colour is credited, and only in the CHECK cycle.
    assign w_credit      = (r_state == CHECK) && credited_win(r_player, win_red, win_grn);
    assign w_inc_red     = w_credit && (r_player == PLR_RED);
    assign w_inc_grn     = w_credit && (r_player == PLR_GRN);
    assign w_match_point = (r_player == PLR_GRN) ? w_grn_match : w_red_match;
    assign w_hold_nxt    = r_hold_cnt + 1'b1;

    score_keeper #(
        .WIN_SCORE (WIN_SCORE)
    ) u_score_keeper (
        .i_clk       (clk),
        .i_rst       (RST),
        .i_inc_red   (w_inc_red),
        .i_inc_grn   (w_inc_grn),
        .o_score_red (scoreR),
        .o_score_grn (scoreG),
        .o_red_match (w_red_match),
        .o_grn_match (w_grn_match)
    );

    // Round/turn state machine with registered pulse and status outputs.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state        <= WAIT_MOVE;
            r_player       <= PLR_RED;
            r_start_player <= PLR_RED;
            r_drop_cnt     <= '0;
            r_hold_cnt     <= '0;
            r_round_won    <= 1'b0;
            r_drop_en      <= 1'b0;
            r_next_round   <= 1'b0;
            r_drop_err     <= 1'b0;
            r_flash        <= 1'b0;
            r_match_over   <= 1'b0;
            r_winner       <= 1'b0;
        end else begin
            // Pulses default low so none can stretch past one cycle.
            r_drop_en    <= 1'b0;
            r_next_round <= 1'b0;
            r_drop_err   <= 1'b0;
            case (r_state)
                WAIT_MOVE: begin
                    if (move_req) begin
                        r_drop_en  <= 1'b1;
                        r_drop_cnt <= '0;
                        r_state    <= DROPPING;
                    end
                end
                DROPPING: begin
                    // A rejected drop (full column) returns the turn to the same player.
                    if (drop_done) begin
                        r_state <= drop_ok ? CHECK : WAIT_MOVE;
                    end else if (r_drop_cnt == LP_DROP_LAST) begin
                        r_drop_err <= 1'b1;
                        r_state    <= WAIT_MOVE;
                    end else begin
                        r_drop_cnt <= r_drop_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    r_hold_cnt <= '0;
                    r_flash    <= 1'b0;
                    if (w_credit) begin
                        r_round_won <= 1'b1;
                        r_state     <= WIN_HOLD;
                    end else if (board_full) begin
                        r_round_won <= 1'b0;
                        r_state     <= WIN_HOLD;
                    end else begin
                        r_player <= ~r_player;
                        r_state  <= WAIT_MOVE;
                    end
                end
                WIN_HOLD: begin
                    if (r_hold_cnt == LP_HOLD_LAST) begin
                        r_flash <= 1'b0;
                        if (r_round_won && w_match_point) begin
                            r_match_over <= 1'b1;
                            r_winner     <= r_player;
                            r_state      <= MATCH_OVER;
                        end else begin
                            r_next_round <= 1'b1;
                            r_state      <= CLEAR;
                        end
                    end else begin
                        r_hold_cnt <= w_hold_nxt;
                        r_flash    <= w_hold_nxt[2];
                    end
                end
                CLEAR: begin
                    // Opening move alternates every round, draws included.
                    r_start_player <= ~r_start_player;
                    r_player       <= ~r_start_player;
                    r_state        <= WAIT_MOVE;
                end
                MATCH_OVER: begin
                    r_state <= MATCH_OVER;
                end
                default: begin
                    r_state <= WAIT_MOVE;
                end
            endcase
        end
    end

    assign player     = r_player;
    assign drop_en    = r_drop_en;
    assign next_round = r_next_round;
    assign drop_err   = r_drop_err;
    assign flash      = r_flash;
    assign match_over = r_match_over;
    assign winner     = r_winner;

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer against a transaction-level game model.
// Latency: n/a.
// Backpressure: n/a.
module tb_match_sequencer;

    localparam int HOLD   = 48;
    localparam int WINS   = 3;
    localparam int TMO    = 15;

    logic       clk = 1'b0;
    logic       RST;
    logic       move_req;
    logic       drop_done;
    logic       drop_ok;
    logic       win_red;
    logic       win_grn;
    logic       board_full;
    logic       player;
    logic       drop_en;
    logic       next_round;
    logic [2:0] scoreR;
    logic [2:0] scoreG;
    logic       flash;
    logic       drop_err;
    logic       match_over;
    logic       winner;

    int n_tests = 0;
    int n_fail  = 0;

    // Game model state: whose turn, who opened the round, scores.
    int m_player;
    int m_start;
    int m_sr;
    int m_sg;

    match_sequencer #(
        .HOLD_CYCLES  (HOLD),
        .WIN_SCORE    (WINS),
        .DROP_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .move_req   (move_req),
        .drop_done  (drop_done),
        .drop_ok    (drop_ok),
        .win_red    (win_red),
        .win_grn    (win_grn),
        .board_full (board_full),
        .player     (player),
        .drop_en    (drop_en),
        .next_round (next_round),
        .scoreR     (scoreR),
        .scoreG     (scoreG),
        .flash      (flash),
        .drop_err   (drop_err),
        .match_over (match_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        move_req   = 1'b0;
        drop_done  = 1'b0;
        drop_ok    = 1'b0;
        win_red    = 1'b0;
        win_grn    = 1'b0;
        board_full = 1'b0;
    endtask

    // Two reset cycles with junk on the inputs to show RST has priority.
    task automatic do_reset();
        RST        = 1'b1;
        move_req   = 1'b1;
        drop_done  = 1'($urandom % 2);
        drop_ok    = 1'($urandom % 2);
        win_red    = 1'($urandom % 2);
        win_grn    = 1'($urandom % 2);
        board_full = 1'($urandom % 2);
        tick();
        tick();
        RST = 1'b0;
        clear_inputs();
        m_player = 0;
        m_start  = 0;
        m_sr     = 0;
        m_sg     = 0;
    endtask

    // Pulse move_req for one cycle; report drop_en in the following cycle.
    task automatic move_start(output logic de);
        move_req = 1'b1;
        tick();
        move_req = 1'b0;
        de = drop_en;
    endtask

    // Finish an in-flight drop after d cycles; if placed, present results during CHECK.
    task automatic drop_finish(input int d, input logic ok, input logic wr, input logic wg,
                               input logic bf, output int de_seen);
        de_seen = 0;
        for (int i = 0; i < d; i++) begin
            move_req = 1'($urandom % 2);
            tick();
            de_seen += int'(drop_en);
        end
        drop_done = 1'b1;
        drop_ok   = ok;
        move_req  = 1'($urandom % 2);
        tick();
        clear_inputs();
        de_seen += int'(drop_en);
        if (ok) begin
            win_red    = wr;
            win_grn    = wg;
            board_full = bf;
            tick();
            clear_inputs();
        end
    endtask

    // Walk the full hold window recording flash and any stray pulses.
    task automatic hold_observe(output logic [HOLD-1:0] fl, output int nr, output int de);
        fl = '0;
        nr = 0;
        de = 0;
        for (int h = 0; h < HOLD; h++) begin
            fl[h] = flash;
            nr += int'(next_round);
            de += int'(drop_en);
            move_req = 1'($urandom % 2);
            tick();
            move_req = 1'b0;
        end
    endtask

    function automatic logic [HOLD-1:0] flash_pattern();
        logic [HOLD-1:0] p;
        for (int h = 0; h < HOLD; h++) p[h] = 1'(((h / 4) % 2) == 1);
        return p;
    endfunction

    task automatic test_reset();
        logic de;
        do_reset();
        if ({player, drop_en, next_round, scoreR, scoreG, flash, drop_err, match_over, winner} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {player, drop_en, next_round, scoreR, scoreG, flash, drop_err, match_over, winner});
        end
        n_tests++;
        tick();
        if (drop_en !== 1'b0) begin n_fail++; $display("FAIL reset_idle_drop_en: got %0d required 0", drop_en); end
        n_tests++;
        move_start(de);
        if (de !== 1'b1) begin n_fail++; $display("FAIL first_drop_en: got %0d required 1", de); end
        n_tests++;
        tick();
        if (drop_en !== 1'b0) begin n_fail++; $display("FAIL drop_en_single: got %0d required 0", drop_en); end
        n_tests++;
    endtask

    task automatic test_retry();
        logic de;
        int   ds;
        do_reset();
        move_start(de);
        drop_finish($urandom_range(0, 14), 1'b0, 1'b0, 1'b0, 1'b0, ds);
        if (player !== 1'b0 || scoreR !== 3'd0 || scoreG !== 3'd0) begin
            n_fail++;
            $display("FAIL retry_reject: got player=%0d R=%0d G=%0d required 0 0 0", player, scoreR, scoreG);
        end
        n_tests++;
        move_start(de);
        if (de !== 1'b1) begin n_fail++; $display("FAIL retry_drop_en: got %0d required 1", de); end
        n_tests++;
        drop_finish($urandom_range(0, 14), 1'b1, 1'b0, 1'b0, 1'b0, ds);
        if (player !== 1'b1) begin n_fail++; $display("FAIL retry_toggle: got %0d required 1", player); end
        n_tests++;
        if (ds !== 0) begin n_fail++; $display("FAIL retry_drop_ignored: got %0d drop_en pulses required 0", ds); end
        n_tests++;
    endtask

    // Red wins the opening round, then a draw round: openers must alternate.
    task automatic test_win_and_draw();
        logic            de;
        int              ds, nr, dh;
        logic [HOLD-1:0] fl;
        do_reset();
        move_start(de);
        drop_finish($urandom_range(0, 14), 1'b1, 1'b1, 1'b0, 1'b0, ds);
        if (scoreR !== 3'd1 || scoreG !== 3'd0) begin
            n_fail++; $display("FAIL red_win_score: got R=%0d G=%0d required 1 0", scoreR, scoreG);
        end
        n_tests++;
        hold_observe(fl, nr, dh);
        if (fl !== flash_pattern()) begin n_fail++; $display("FAIL win_flash: got %h required %h", fl, flash_pattern()); end
        n_tests++;
        if (nr !== 0 || dh !== 0) begin n_fail++; $display("FAIL win_hold_quiet: got nr=%0d de=%0d required 0 0", nr, dh); end
        n_tests++;
        if (next_round !== 1'b1 || flash !== 1'b0) begin
            n_fail++; $display("FAIL win_next_round: got nr=%0d flash=%0d required 1 0", next_round, flash);
        end
        n_tests++;
        tick();
        if (next_round !== 1'b0 || player !== 1'b1) begin
            n_fail++; $display("FAIL win_new_round: got nr=%0d player=%0d required 0 1", next_round, player);
        end
        n_tests++;
        move_start(de);
        drop_finish($urandom_range(0, 14), 1'b1, 1'b0, 1'b0, 1'b1, ds);
        if (scoreR !== 3'd1 || scoreG !== 3'd0) begin
            n_fail++; $display("FAIL draw_score: got R=%0d G=%0d required 1 0", scoreR, scoreG);
        end
        n_tests++;
        hold_observe(fl, nr, dh);
        if (next_round !== 1'b1 || nr !== 0) begin
            n_fail++; $display("FAIL draw_next_round: got nr=%0d early=%0d required 1 0", next_round, nr);
        end
        n_tests++;
        tick();
        if (player !== 1'b0) begin n_fail++; $display("FAIL draw_start_alternates: got %0d required 0", player); end
        n_tests++;
    endtask

    task automatic test_timeout();
        logic de;
        int   ds, first, errs, des;
        do_reset();
        move_start(de);
        drop_finish($urandom_range(0, 14), 1'b1, 1'b0, 1'b0, 1'b0, ds);
        move_start(de);
        first = -1;
        errs  = 0;
        des   = 0;
        for (int i = 1; i <= 25; i++) begin
            move_req = (i <= 14) ? 1'($urandom % 2) : 1'b0;
            tick();
            move_req = 1'b0;
            if (drop_err === 1'b1) begin
                errs++;
                if (first < 0) first = i;
            end
            des += int'(drop_en);
        end
        if (first !== TMO) begin n_fail++; $display("FAIL timeout_cycle: got %0d required %0d", first, TMO); end
        n_tests++;
        if (errs !== 1 || des !== 0) begin
            n_fail++; $display("FAIL timeout_pulses: got err=%0d drop_en=%0d required 1 0", errs, des);
        end
        n_tests++;
        if (player !== 1'b1) begin n_fail++; $display("FAIL timeout_player: got %0d required 1", player); end
        n_tests++;
        move_start(de);
        if (de !== 1'b1) begin n_fail++; $display("FAIL timeout_wait_move: got %0d required 1", de); end
        n_tests++;
        drop_finish(14, 1'b1, 1'b0, 1'b0, 1'b0, ds);
        if (player !== 1'b0) begin n_fail++; $display("FAIL late_drop_accepted: got player=%0d required 0", player); end
        n_tests++;
    endtask

    task automatic test_reset_mid_hold();
        logic de;
        int   ds;
        do_reset();
        move_start(de);
        drop_finish($urandom_range(0, 14), 1'b1, 1'b1, 1'b0, 1'b0, ds);
        repeat ($urandom_range(5, 40)) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        if ({player, drop_en, next_round, scoreR, scoreG, flash, drop_err, match_over, winner} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got %b required all zero",
                     {player, drop_en, next_round, scoreR, scoreG, flash, drop_err, match_over, winner});
        end
        n_tests++;
        move_start(de);
        if (de !== 1'b1) begin n_fail++; $display("FAIL reset_mid_hold_move: got %0d required 1", de); end
        n_tests++;
    endtask

    // Random moves and outcomes against the game model until the match ends.
    task automatic test_random_match();
        logic            de, ok, wr, wg, bf, mine, opp;
        int              ds, nr, dh, outcome, credited, drawn, done, sc;
        logic [HOLD-1:0] fl;
        do_reset();
        done = 0;
        for (int mv = 0; mv < 300 && done == 0; mv++) begin
            ok      = 1'(($urandom % 5) != 0);
            outcome = int'($urandom % 5);
            mine    = 1'b0;
            opp     = 1'b0;
            bf      = 1'b0;
            case (outcome)
                1: begin mine = 1'b1; bf = 1'($urandom % 2); end
                2: opp = 1'b1;
                3: begin bf = 1'b1; opp = 1'($urandom % 2); end
                4: begin mine = 1'b1; opp = 1'b1; bf = 1'($urandom % 2); end
                default: ;
            endcase
            wr = (m_player == 0) ? mine : opp;
            wg = (m_player == 0) ? opp : mine;
            move_start(de);
            if (de !== 1'b1) begin n_fail++; $display("FAIL rnd_drop_en: got %0d required 1", de); end
            n_tests++;
            drop_finish($urandom_range(0, 14), ok, wr, wg, bf, ds);
            if (ds !== 0) begin n_fail++; $display("FAIL rnd_drop_ignored: got %0d required 0", ds); end
            n_tests++;
            if (!ok) begin
                if (player !== 1'(m_player)) begin
                    n_fail++; $display("FAIL rnd_reject_player: got %0d required %0d", player, m_player);
                end
                n_tests++;
                continue;
            end
            credited = int'(mine);
            drawn    = int'(!mine && bf);
            sc       = 0;
            if (credited != 0) begin
                if (m_player == 0) begin if (m_sr < 7) m_sr++; sc = m_sr; end
                else begin if (m_sg < 7) m_sg++; sc = m_sg; end
            end
            if (scoreR !== 3'(m_sr) || scoreG !== 3'(m_sg)) begin
                n_fail++; $display("FAIL rnd_scores: got R=%0d G=%0d required %0d %0d", scoreR, scoreG, m_sr, m_sg);
            end
            n_tests++;
            if (credited == 0 && drawn == 0) begin
                m_player ^= 1;
                if (player !== 1'(m_player)) begin
                    n_fail++; $display("FAIL rnd_turn: got %0d required %0d", player, m_player);
                end
                n_tests++;
                continue;
            end
            hold_observe(fl, nr, dh);
            if (fl !== flash_pattern() || nr !== 0 || dh !== 0) begin
                n_fail++; $display("FAIL rnd_hold: got flash=%h nr=%0d de=%0d required %h 0 0", fl, nr, dh, flash_pattern());
            end
            n_tests++;
            if (credited != 0 && sc == WINS) begin
                if (match_over !== 1'b1 || winner !== 1'(m_player) || next_round !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_match_over: got mo=%0d win=%0d nr=%0d required 1 %0d 0",
                             match_over, winner, next_round, m_player);
                end
                n_tests++;
                done = 1;
            end else begin
                if (next_round !== 1'b1 || match_over !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_clear: got nr=%0d mo=%0d required 1 0", next_round, match_over);
                end
                n_tests++;
                tick();
                m_start ^= 1;
                m_player = m_start;
                if (player !== 1'(m_player) || next_round !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_new_round: got player=%0d nr=%0d required %0d 0", player, next_round, m_player);
                end
                n_tests++;
            end
        end
        if (done !== 1) begin n_fail++; $display("FAIL rnd_match_end: got %0d required 1", done); end
        n_tests++;
        // Once decided, nothing moves: no drops, no clears, flash off.
        nr = 0;
        dh = 0;
        for (int i = 0; i < 30; i++) begin
            move_req  = 1'($urandom % 2);
            drop_done = 1'($urandom % 2);
            drop_ok   = 1'b1;
            win_red   = 1'($urandom % 2);
            win_grn   = 1'($urandom % 2);
            tick();
            nr += int'(next_round) + int'(flash) + int'(drop_err);
            dh += int'(drop_en);
        end
        clear_inputs();
        if (nr !== 0 || dh !== 0 || match_over !== 1'b1 || scoreR !== 3'(m_sr) || scoreG !== 3'(m_sg)) begin
            n_fail++;
            $display("FAIL match_frozen: got act=%0d de=%0d mo=%0d R=%0d G=%0d required 0 0 1 %0d %0d",
                     nr, dh, match_over, scoreR, scoreG, m_sr, m_sg);
        end
        n_tests++;
    endtask

    // Green takes three rounds; red opens odd rounds with a harmless move.
    task automatic test_green_match();
        logic            de;
        int              ds, nr, dh;
        logic [HOLD-1:0] fl;
        do_reset();
        for (int r = 0; r < WINS; r++) begin
            if (player === 1'b0) begin
                move_start(de);
                drop_finish($urandom_range(0, 14), 1'b1, 1'b0, 1'b0, 1'b0, ds);
            end
            move_start(de);
            drop_finish($urandom_range(0, 14), 1'b1, 1'($urandom % 2), 1'b1, 1'b0, ds);
            if (scoreG !== 3'(r + 1) || scoreR !== 3'd0) begin
                n_fail++; $display("FAIL green_score: got G=%0d R=%0d required %0d 0", scoreG, scoreR, r + 1);
            end
            n_tests++;
            hold_observe(fl, nr, dh);
            if (r < WINS - 1) begin
                if (next_round !== 1'b1) begin n_fail++; $display("FAIL green_clear: got %0d required 1", next_round); end
                n_tests++;
                tick();
            end else begin
                if (match_over !== 1'b1 || winner !== 1'b1 || next_round !== 1'b0 || nr !== 0) begin
                    n_fail++;
                    $display("FAIL green_match_over: got mo=%0d win=%0d nr=%0d/%0d required 1 1 0 0",
                             match_over, winner, next_round, nr);
                end
                n_tests++;
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        test_reset();
        test_retry();
        test_win_and_draw();
        test_timeout();
        test_reset_mid_hold();
        test_green_match();
        for (int k = 0; k < 4; k++) test_random_match();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
